// File: rtl/psum_requant.sv
// Column partial-sum accumulator with requantisation (round, shift, ReLU, saturate)
// and a small output FIFO with valid/ready toward the activation writer.
module psum_requant #(
    parameter int CW    = 16,
    parameter int DW    = 8,
    parameter int AW    = 24,
    parameter int KW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [KW-1:0] cfg_passes,
    input  logic [4:0]    cfg_shift,
    input  logic          cfg_relu,
    input  logic [CW-1:0] cfg_bias,
    input  logic          psum_valid,
    input  logic [CW:0]   psum,
    output logic          psum_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    input  logic          sat_clr,
    output logic          sat_flag,
    output logic          busy
);
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic signed [AW:0] SAT_MAX = {{(AW-DW+2){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN = {{(AW-DW+2){1'b1}}, {(DW-1){1'b0}}};

    logic signed [AW-1:0] acc;
    logic [KW-1:0]        pass_cnt;
    logic [KW-1:0]        passes_l;
    logic [4:0]           shift_l;
    logic                 relu_l;

    logic signed [AW-1:0] rq_r;
    logic [4:0]           rq_shift;
    logic                 rq_relu;
    logic                 rq_vld;

    logic [DW-1:0]        mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CNT_W-1:0]     fifo_cnt;

    logic                 accept;
    logic                 first;
    logic                 last;
    logic [KW-1:0]        passes_eff;
    logic [KW-1:0]        grp_passes;
    logic [4:0]           grp_shift;
    logic                 grp_relu;
    logic signed [AW-1:0] psum_x;
    logic signed [AW-1:0] bias_x;
    logic signed [AW-1:0] sum;

    logic signed [AW:0]   rnd;
    logic signed [AW:0]   r_sum;
    logic signed [AW:0]   r_sh;
    logic signed [AW:0]   r_rl;
    logic [DW-1:0]        q;
    logic                 q_sat;

    logic                 push;
    logic                 pop;
    logic [CNT_W:0]       occ;

    // Stage A: group bookkeeping; the first psum of a group takes the live config
    always_comb begin
        accept     = psum_valid && psum_ready;
        first      = (pass_cnt == '0);
        psum_x     = {{(AW-CW-1){psum[CW]}}, psum};
        bias_x     = {{(AW-CW){cfg_bias[CW-1]}}, cfg_bias};
        passes_eff = (cfg_passes == '0) ? KW'(1) : cfg_passes;
        grp_passes = first ? passes_eff : passes_l;
        grp_shift  = first ? cfg_shift : shift_l;
        grp_relu   = first ? cfg_relu : relu_l;
        sum        = (first ? bias_x : acc) + psum_x;
        last       = (pass_cnt == grp_passes - KW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            pass_cnt <= '0;
            passes_l <= KW'(1);
            shift_l  <= '0;
            relu_l   <= 1'b0;
            rq_r     <= '0;
            rq_shift <= '0;
            rq_relu  <= 1'b0;
            rq_vld   <= 1'b0;
        end else begin
            rq_vld <= accept && last;
            if (accept) begin
                acc <= sum;
                if (first) begin
                    passes_l <= passes_eff;
                    shift_l  <= cfg_shift;
                    relu_l   <= cfg_relu;
                end
                if (last) begin
                    rq_r     <= sum;
                    rq_shift <= grp_shift;
                    rq_relu  <= grp_relu;
                    pass_cnt <= '0;
                end else begin
                    pass_cnt <= pass_cnt + 1'b1;
                end
            end
        end
    end

    // Stage B: one extra bit so the rounding add cannot wrap before the shift
    always_comb begin
        rnd   = (rq_shift == 5'd0) ? '0 : ({{AW{1'b0}}, 1'b1} << (rq_shift - 5'd1));
        r_sum = {rq_r[AW-1], rq_r} + rnd;
        r_sh  = r_sum >>> rq_shift;
        r_rl  = (rq_relu && r_sh[AW]) ? '0 : r_sh;
        q     = r_rl[DW-1:0];
        q_sat = 1'b0;
        if (r_rl > SAT_MAX) begin
            q     = {1'b0, {(DW-1){1'b1}}};
            q_sat = 1'b1;
        end else if (r_rl < SAT_MIN) begin
            q     = {1'b1, {(DW-1){1'b0}}};
            q_sat = 1'b1;
        end
    end

    // Output FIFO: psum_ready reserves a slot for every result already in flight
    always_comb begin
        push       = rq_vld;
        out_valid  = (fifo_cnt != '0);
        pop        = out_valid && out_ready;
        out_data   = mem[rd_ptr];
        occ        = {1'b0, fifo_cnt} + {{CNT_W{1'b0}}, rq_vld};
        psum_ready = (occ < (CNT_W+1)'(DEPTH));
        busy       = (pass_cnt != '0) || rq_vld || (fifo_cnt != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            sat_flag <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= q;
                wr_ptr      <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (pop && !push) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
            if (push && q_sat) begin
                sat_flag <= 1'b1;
            end else if (sat_clr) begin
                sat_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_psum_requant.sv
// Bench for psum_requant: group-level arithmetic model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_psum_requant;
    localparam int CW = 16, DW = 8, AW = 24, KW = 8, DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] cfg_passes = '0;
    logic [4:0]    cfg_shift = '0;
    logic          cfg_relu = 1'b0;
    logic [CW-1:0] cfg_bias = '0;
    logic          psum_valid = 1'b0;
    logic [CW:0]   psum = '0;
    logic          psum_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          sat_clr = 1'b0;
    logic          sat_flag;
    logic          busy;

    psum_requant #(.CW(CW), .DW(DW), .AW(AW), .KW(KW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_passes(cfg_passes), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .cfg_bias(cfg_bias), .psum_valid(psum_valid), .psum(psum),
        .psum_ready(psum_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .sat_clr(sat_clr), .sat_flag(sat_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    int     grp_n = 0;
    int     grp_passes = 1;
    int     grp_shift = 0;
    bit     grp_relu = 0;
    longint grp_sum = 0;
    bit     pend = 0;
    bit     pend_sat = 0;
    bit     sat_m = 0;
    bit     acc_prev = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Returns {saturated, activation}
    function automatic logic [DW:0] requant(input longint total, input int shift, input bit relu);
        longint t;
        logic [DW:0] r;
        t = total & ((longint'(1) << AW) - 1);
        if (t >= (longint'(1) << (AW-1))) t = t - (longint'(1) << AW);
        if (shift > 0) t = t + (longint'(1) << (shift-1));
        t = t >>> shift;
        if (relu && t < 0) t = 0;
        r[DW] = 1'b0;
        if (t > 127) begin
            t = 127; r[DW] = 1'b1;
        end else if (t < -128) begin
            t = -128; r[DW] = 1'b1;
        end
        r[DW-1:0] = t[DW-1:0];
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [DW:0] r;
        if (!rst_n) begin
            exp_q.delete();
            grp_n = 0; pend = 0; pend_sat = 0; sat_m = 0;
        end else begin
            if (pend && pend_sat) sat_m = 1;
            else if (sat_clr) sat_m = 0;
            pend = 0;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
            if (psum_valid && psum_ready) begin
                if (grp_n == 0) begin
                    grp_passes = (cfg_passes == 0) ? 1 : int'(cfg_passes);
                    grp_shift  = int'(cfg_shift);
                    grp_relu   = cfg_relu;
                    grp_sum    = longint'($signed(cfg_bias));
                end
                grp_sum = grp_sum + longint'($signed(psum));
                grp_n++;
                if (grp_n == grp_passes) begin
                    r = requant(grp_sum, grp_shift, grp_relu);
                    exp_q.push_back(r[DW-1:0]);
                    pend = 1; pend_sat = r[DW];
                    grp_n = 0;
                end
            end
        end
    end

    // Per-cycle compare of every observable output against the model
    always @(negedge clk) begin
        int held;
        if (rst_n) begin
            held = exp_q.size() - (pend ? 1 : 0);
            check("psum_ready", psum_ready, exp_q.size() < DEPTH);
            check("busy", busy, (grp_n != 0) || (exp_q.size() != 0));
            check("out_valid", out_valid, held != 0);
            check("sat_flag", sat_flag, sat_m);
            if (held != 0) check("out_data", out_data, exp_q[0]);
        end
    end

    task automatic set_cfg(input int passes, input int shift, input bit relu, input int bias);
        @(negedge clk);
        cfg_passes = KW'(passes);
        cfg_shift  = 5'(shift);
        cfg_relu   = relu;
        cfg_bias   = CW'(bias);
    endtask

    task automatic send(input int v);
        bit ok;
        ok = 0;
        @(negedge clk);
        psum_valid = 1'b1;
        psum = v[CW:0];
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (psum_ready) begin
                ok = 1;
                break;
            end
        end
        check("send_accept", ok, 1);
    endtask

    task automatic drop();
        @(negedge clk);
        psum_valid = 1'b0;
    endtask

    task automatic expect_pop(input string name, input logic [DW-1:0] exp);
        bit seen;
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        check({name, "_valid"}, seen, 1);
        check(name, out_data, exp);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [CW:0] rand_psum();
        int v;
        if ($urandom_range(0, 3) == 0) begin
            v = int'($urandom);
        end else begin
            v = int'($urandom_range(0, 600)) - 300;
        end
        return v[CW:0];
    endfunction

    initial begin
        logic [DW:0] m;
        int acc_n;
        // Model pins against hand-computed values
        m = requant(260, 2, 0);   check("model_260_s2", m, {1'b0, 8'h41});
        m = requant(-7, 2, 0);    check("model_m7_s2", m, {1'b0, 8'hFE});
        m = requant(1000, 0, 0);  check("model_1000_sat", m, {1'b1, 8'h7F});
        m = requant(-1000, 0, 1); check("model_relu", m, {1'b0, 8'h00});

        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_psum_ready", psum_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sat_flag", sat_flag, 0);
        rst_n = 1'b1;

        // Single pass, identity
        set_cfg(1, 0, 0, 0);
        send(5); drop();
        expect_pop("t1_out", 8'h05);

        // Three passes with bias and rounding shift
        set_cfg(3, 2, 0, 10);
        send(100); send(200); send(-50); drop();
        expect_pop("t2_out", 8'h41);

        // Saturation, ReLU, sticky flag and clear
        set_cfg(1, 0, 0, 0);
        send(1000); drop();
        expect_pop("t3_pos_sat", 8'h7F);
        check("t3_sat_set", sat_flag, 1);
        send(-1000); drop();
        expect_pop("t3_neg_sat", 8'h80);
        set_cfg(1, 0, 1, 0);
        send(-1000); drop();
        expect_pop("t3_relu", 8'h00);
        @(negedge clk); sat_clr = 1'b1;
        @(negedge clk); sat_clr = 1'b0;
        check("t3_sat_clr", sat_flag, 0);

        // Round-half-up on negative and positive values
        set_cfg(1, 2, 0, 0);
        send(-6); send(-7); send(6); drop();
        expect_pop("t4_m6", 8'hFF);
        expect_pop("t4_m7", 8'hFE);
        expect_pop("t4_p6", 8'h02);

        // Backpressure: four results fit, then psum_ready drops
        set_cfg(1, 0, 0, 0);
        got_q.delete();
        acc_n = 0;
        @(negedge clk); psum_valid = 1'b1; psum = 17'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            if (psum_ready) acc_n++;
            @(negedge clk);
            psum = 17'(acc_n + 1);
        end
        check("t5_accepted", acc_n, 4);
        check("t5_ready_low", psum_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 50 && acc_n < 6; i++) begin
            @(posedge clk);
            if (psum_ready) acc_n++;
            @(negedge clk);
            if (acc_n < 6) psum = 17'(acc_n + 1);
            else psum_valid = 1'b0;
        end
        psum_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check("t5_count", got_q.size(), 6);
        for (int j = 0; j < 6 && j < got_q.size(); j++) check("t5_order", got_q[j], j + 1);
        out_ready = 1'b0;

        // Reset in the middle of a group
        set_cfg(4, 0, 0, 0);
        send(7); send(8); drop();
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_out_valid", out_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_psum_ready", psum_ready, 1);
        rst_n = 1'b1;
        send(1); send(2); send(3); send(4); drop();
        expect_pop("t6_sum", 8'h0A);

        // Randomized traffic; config also changes mid-group
        acc_prev = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (!psum_valid || acc_prev) begin
                psum_valid = ($urandom_range(0, 2) != 0);
                psum = rand_psum();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 7) == 0) begin
                cfg_passes = ($urandom_range(0, 40) == 0) ? KW'($urandom_range(200, 255))
                                                           : KW'($urandom_range(0, 5));
                cfg_shift  = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(13, 23))
                                                         : 5'($urandom_range(0, 10));
                cfg_relu   = 1'($urandom_range(0, 1));
                cfg_bias   = CW'($urandom);
            end
            @(posedge clk);
            acc_prev = psum_valid && psum_ready;
        end

        // Finish the open group and drain
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            sat_clr = 1'b0;
            if (!(psum_valid && !acc_prev)) begin
                if (grp_n != 0) begin
                    psum_valid = 1'b1;
                    psum = rand_psum();
                end else begin
                    psum_valid = 1'b0;
                end
            end
            @(posedge clk);
            acc_prev = psum_valid && psum_ready;
            if (!psum_valid && grp_n == 0 && exp_q.size() == 0) break;
        end
        @(negedge clk);
        check("drain_empty", exp_q.size(), 0);
        check("drain_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
